// File: rtl/svo_pong_sched.sv
// Frame-synchronous pong game sequencer: derives game ticks and serve
// pulses from the video stream start-of-frame, and tracks score and pause.
module svo_pong_sched #(
   parameter int SERVE_FRAMES = 60,
   parameter int TICK_DIV     = 1,
   parameter int WIN_SCORE    = 11,
   parameter int SCORE_BITS   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  vid_tvalid,
   input  logic                  vid_tready,
   input  logic                  vid_tuser,
   input  logic                  miss_left,
   input  logic                  miss_right,
   input  logic                  btn_start,
   input  logic                  btn_pause,
   output logic                  game_tick,
   output logic                  serve,
   output logic                  serve_dir,
   output logic [SCORE_BITS-1:0] score_left,
   output logic [SCORE_BITS-1:0] score_right,
   output logic [2:0]            state,
   output logic                  paused,
   output logic                  game_over
);

   localparam logic [2:0] ST_ATTRACT = 3'd0;
   localparam logic [2:0] ST_SERVE   = 3'd1;
   localparam logic [2:0] ST_PLAY    = 3'd2;
   localparam logic [2:0] ST_POINT   = 3'd3;
   localparam logic [2:0] ST_OVER    = 3'd4;

   localparam logic [7:0] SF_LAST = 8'(SERVE_FRAMES - 1);
   localparam logic [3:0] TD_LAST = 4'(TICK_DIV - 1);
   localparam logic [SCORE_BITS-1:0] WIN   = SCORE_BITS'(WIN_SCORE);
   localparam logic [SCORE_BITS-1:0] S_ONE = SCORE_BITS'(1);

   logic [2:0]            state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [3:0]            div_q, div_d;
   logic [SCORE_BITS-1:0] sl_q, sl_d;
   logic [SCORE_BITS-1:0] sr_q, sr_d;
   logic                  dir_q, dir_d;
   logic                  paused_q, paused_d;
   logic                  tick_q, tick_d;
   logic                  serve_q, serve_d;
   logic [1:0]            start_sync_q, pause_sync_q;
   logic                  start_prev_q, pause_prev_q;

   logic sof, start_e, pause_e;

   assign sof     = vid_tvalid & vid_tready & vid_tuser;
   assign start_e = start_sync_q[1] & ~start_prev_q;
   assign pause_e = pause_sync_q[1] & ~pause_prev_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      sl_d     = sl_q;
      sr_d     = sr_q;
      dir_d    = dir_q;
      paused_d = paused_q;
      tick_d   = 1'b0;
      serve_d  = 1'b0;
      unique case (state_q)
         ST_ATTRACT: begin
            tick_d = sof;
            if (start_e) begin
               sl_d    = '0;
               sr_d    = '0;
               cnt_d   = '0;
               dir_d   = 1'b1;
               state_d = ST_SERVE;
            end
         end
         ST_SERVE: begin
            if (pause_e) paused_d = ~paused_q;
            if (sof && !paused_q) begin
               if (cnt_q == SF_LAST) begin
                  cnt_d   = '0;
                  div_d   = '0;
                  serve_d = 1'b1;
                  state_d = ST_PLAY;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         ST_PLAY: begin
            if (pause_e) paused_d = ~paused_q;
            if (sof && !paused_q) begin
               if (div_q == TD_LAST) begin
                  tick_d = 1'b1;
                  div_d  = '0;
               end else begin
                  div_d = div_q + 4'd1;
               end
            end
            // a miss is scored even while paused; both at once is a let
            if (miss_left || miss_right) begin
               state_d  = ST_POINT;
               paused_d = 1'b0;
               if (miss_left && !miss_right) begin
                  if (sr_q != WIN) sr_d = sr_q + S_ONE;
                  dir_d = 1'b0;
               end else if (miss_right && !miss_left) begin
                  if (sl_q != WIN) sl_d = sl_q + S_ONE;
                  dir_d = 1'b1;
               end
            end
         end
         ST_POINT: begin
            if (sof) begin
               if (sl_q == WIN || sr_q == WIN) begin
                  state_d = ST_OVER;
               end else begin
                  state_d = ST_SERVE;
                  cnt_d   = '0;
               end
            end
         end
         ST_OVER: begin
            if (start_e) begin
               sl_d    = '0;
               sr_d    = '0;
               cnt_d   = '0;
               dir_d   = 1'b1;
               state_d = ST_SERVE;
            end
         end
         default: begin
            state_d  = ST_ATTRACT;
            paused_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_ATTRACT;
         cnt_q        <= '0;
         div_q        <= '0;
         sl_q         <= '0;
         sr_q         <= '0;
         dir_q        <= 1'b1;
         paused_q     <= 1'b0;
         tick_q       <= 1'b0;
         serve_q      <= 1'b0;
         start_sync_q <= '0;
         pause_sync_q <= '0;
         start_prev_q <= 1'b0;
         pause_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         div_q        <= div_d;
         sl_q         <= sl_d;
         sr_q         <= sr_d;
         dir_q        <= dir_d;
         paused_q     <= paused_d;
         tick_q       <= tick_d;
         serve_q      <= serve_d;
         start_sync_q <= {start_sync_q[0], btn_start};
         pause_sync_q <= {pause_sync_q[0], btn_pause};
         start_prev_q <= start_sync_q[1];
         pause_prev_q <= pause_sync_q[1];
      end
   end

   assign game_tick   = tick_q;
   assign serve       = serve_q;
   assign serve_dir   = dir_q;
   assign score_left  = sl_q;
   assign score_right = sr_q;
   assign state       = state_q;
   assign paused      = paused_q;
   assign game_over   = (state_q == ST_OVER);

endmodule

// File: tb/tb_svo_pong_sched.sv
// Scoreboard bench for svo_pong_sched: frame results are queued when a
// start-of-frame is driven and compared when the registered outputs appear.
module tb_svo_pong_sched;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       vid_tvalid = 1'b0, vid_tready = 1'b0, vid_tuser = 1'b0;
   logic       miss_left = 1'b0, miss_right = 1'b0;
   logic       btn_start = 1'b0, btn_pause = 1'b0;
   logic       game_tick, serve, serve_dir, paused, game_over;
   logic [3:0] score_left, score_right;
   logic [2:0] state;

   typedef struct {
      logic       tick;
      logic       srv;
      logic [2:0] st;
   } exp_t;

   exp_t sbq[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   ticks = 0;
   int   t0;

   svo_pong_sched #(
      .SERVE_FRAMES(4),
      .TICK_DIV(3),
      .WIN_SCORE(2),
      .SCORE_BITS(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .vid_tvalid(vid_tvalid),
      .vid_tready(vid_tready),
      .vid_tuser(vid_tuser),
      .miss_left(miss_left),
      .miss_right(miss_right),
      .btn_start(btn_start),
      .btn_pause(btn_pause),
      .game_tick(game_tick),
      .serve(serve),
      .serve_dir(serve_dir),
      .score_left(score_left),
      .score_right(score_right),
      .state(state),
      .paused(paused),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (game_tick) ticks++;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present one sof beat; rdy=0 gives a stalled beat that is no frame start.
   task automatic frame(input logic rdy, input logic et, input logic es,
                        input logic [2:0] est);
      exp_t e;
      vid_tvalid = 1'b1;
      vid_tready = rdy;
      vid_tuser  = 1'b1;
      sbq.push_back('{tick: et, srv: es, st: est});
      @(negedge clk);
      vid_tvalid = 1'b0;
      vid_tready = 1'b1;
      vid_tuser  = 1'b0;
      e = sbq.pop_front();
      chk("tick", {31'd0, game_tick}, {31'd0, e.tick});
      chk("serve", {31'd0, serve}, {31'd0, e.srv});
      chk("state", {29'd0, state}, {29'd0, e.st});
      @(negedge clk);
      chk("tick_width", {31'd0, game_tick}, 32'd0);
      chk("serve_width", {31'd0, serve}, 32'd0);
      @(negedge clk);
   endtask

   task automatic press_start();
      btn_start = 1'b1;
      repeat (6) @(negedge clk);
      btn_start = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic press_pause();
      btn_pause = 1'b1;
      repeat (6) @(negedge clk);
      btn_pause = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic miss(input logic l, input logic r);
      miss_left  = l;
      miss_right = r;
      @(negedge clk);
      miss_left  = 1'b0;
      miss_right = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_scores(input int sl, input int sr, input int st,
                             input int dir);
      chk("score_left", {28'd0, score_left}, sl);
      chk("score_right", {28'd0, score_right}, sr);
      chk("state_now", {29'd0, state}, st);
      chk("serve_dir", {31'd0, serve_dir}, dir);
   endtask

   task automatic serve_seq(input int dir);
      for (int i = 0; i < 3; i++) frame(1'b1, 1'b0, 1'b0, 3'd1);
      frame(1'b1, 1'b0, 1'b1, 3'd2);
      chk("dir_at_serve", {31'd0, serve_dir}, dir);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk_scores(0, 0, 0, 1);
      chk("rst_tick", {31'd0, game_tick}, 0);
      chk("rst_paused", {31'd0, paused}, 0);
      chk("rst_over", {31'd0, game_over}, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // attract mode ticks on every completed sof only
      t0 = ticks;
      for (int i = 0; i < 3; i++) frame(1'b1, 1'b1, 1'b0, 3'd0);
      frame(1'b0, 1'b0, 1'b0, 3'd0);
      chk("attract_ticks", ticks - t0, 3);
      press_pause();
      chk("attract_pause", {31'd0, paused}, 0);

      press_start();
      chk_scores(0, 0, 1, 1);
      t0 = ticks;
      serve_seq(1);
      chk("serve_no_tick", ticks - t0, 0);

      // TICK_DIV=3: ticks after the 3rd, 6th and 9th real frame
      t0 = ticks;
      for (int i = 1; i <= 9; i++) begin
         if (i == 3) frame(1'b0, 1'b0, 1'b0, 3'd2);
         frame(1'b1, (i % 3) == 0, 1'b0, 3'd2);
      end
      chk("play_ticks", ticks - t0, 3);

      frame(1'b1, 1'b0, 1'b0, 3'd2);
      press_pause();
      chk("play_paused", {31'd0, paused}, 1);
      for (int i = 0; i < 5; i++) frame(1'b1, 1'b0, 1'b0, 3'd2);
      press_pause();
      chk("play_unpaused", {31'd0, paused}, 0);
      frame(1'b1, 1'b0, 1'b0, 3'd2);
      frame(1'b1, 1'b1, 1'b0, 3'd2);

      miss(1'b1, 1'b0);
      chk_scores(0, 1, 3, 0);
      frame(1'b1, 1'b0, 1'b0, 3'd1);
      serve_seq(0);

      miss(1'b1, 1'b1);
      chk_scores(0, 1, 3, 0);
      frame(1'b1, 1'b0, 1'b0, 3'd1);
      serve_seq(0);

      miss(1'b0, 1'b1);
      chk_scores(1, 1, 3, 1);
      frame(1'b1, 1'b0, 1'b0, 3'd1);
      serve_seq(1);
      miss(1'b0, 1'b1);
      chk_scores(2, 1, 3, 1);
      frame(1'b1, 1'b0, 1'b0, 3'd4);
      chk("game_over", {31'd0, game_over}, 1);
      miss(1'b1, 1'b0);
      chk_scores(2, 1, 4, 1);
      frame(1'b1, 1'b0, 1'b0, 3'd4);

      press_start();
      chk_scores(0, 0, 1, 1);
      chk("over_cleared", {31'd0, game_over}, 0);

      // serve counter frozen while paused, then async reset mid-serve
      frame(1'b1, 1'b0, 1'b0, 3'd1);
      frame(1'b1, 1'b0, 1'b0, 3'd1);
      press_pause();
      chk("serve_paused", {31'd0, paused}, 1);
      for (int i = 0; i < 3; i++) frame(1'b1, 1'b0, 1'b0, 3'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_state", {29'd0, state}, 0);
      chk("async_paused", {31'd0, paused}, 0);
      chk("async_dir", {31'd0, serve_dir}, 1);
      @(negedge clk);
      reset = 1'b0;
      t0 = ticks;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_serve", {31'd0, serve}, 0);
      end
      chk("post_rst_ticks", ticks - t0, 0);
      frame(1'b1, 1'b1, 1'b0, 3'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/svo_pong_sched.md
Name: svo_pong_sched

Overview:
- Frame-synchronous game sequencer for the pong video pipeline.
- Watches the pixel AXI-stream handshake for start-of-frame and decides when the game-state update logic may advance (game_tick).
- Issues serve pulses, tracks scores and manages pause and game-over.
- Sits beside the pong renderer: it drives the renderer's update-enable and serve inputs and consumes the renderer's miss pulses.

Parameters:
SERVE_FRAMES, 60, frames spent in SERVE before the ball is released (1..255)
TICK_DIV, 1, game_tick issued every TICK_DIV-th frame in PLAY (1..15)
WIN_SCORE, 11, score that ends the game (1..2^SCORE_BITS-1)
SCORE_BITS, 4, width of each score counter

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
vid_tvalid  in  1  tvalid of the renderer output stream (monitor only)
vid_tready  in  1  tready of the renderer output stream (monitor only)
vid_tuser  in  1  tuser[0] start-of-frame of the renderer output stream
miss_left  in  1  one-cycle pulse: ball passed the left paddle
miss_right  in  1  one-cycle pulse: ball passed the right paddle
btn_start  in  1  asynchronous level button
btn_pause  in  1  asynchronous level button
game_tick  out  1  one-cycle update enable for the game-state logic
serve  out  1  one-cycle pulse: re-centre ball and launch it
serve_dir  out  1  1 = launch toward right player, 0 = toward left
score_left  out  SCORE_BITS  left player score
score_right  out  SCORE_BITS  right player score
state  out  3  0 ATTRACT, 1 SERVE, 2 PLAY, 3 POINT, 4 OVER
paused  out  1  pause active
game_over  out  1  high while state==OVER

Behaviour:
- Reset (async assert, sync release):
  - state=ATTRACT, serve_dir=1.
  - All other outputs, counters and synchroniser flops are 0.
- sof = vid_tvalid & vid_tready & vid_tuser, sampled at clk.
  - game_tick and every frame-counter action occur in the cycle after sof (registered, latency 1).
- Buttons:
  - Each button passes through a 2-flop synchroniser, then a rising-edge detector.
  - An edge is seen 3 cycles after the input rises.
  - A held button produces one edge only.
- ATTRACT:
  - game_tick on every sof, so the demo plays itself.
  - Misses are ignored and scores are held at 0.
  - Start edge: scores cleared, frame counter cleared, serve_dir=1, go to SERVE.
- SERVE:
  - Count sofs.
  - When the count reaches SERVE_FRAMES: assert serve for one cycle, coincident with the first PLAY cycle, and clear the counter.
  - No game_tick is issued in SERVE.
- PLAY:
  - Tick divider counts sofs.
  - game_tick on each sof where divider==TICK_DIV-1, then divider wraps to 0.
  - TICK_DIV=1 ticks every frame.
- PLAY, miss handling:
  - miss_left only: score_right+1, serve_dir=0, go to POINT.
  - miss_right only: score_left+1, serve_dir=1, go to POINT.
  - Both in the same cycle: no score change, serve_dir unchanged, go to POINT.
  - Misses in any state other than PLAY are ignored.
- POINT:
  - Wait for the next sof.
  - Then go to OVER if either score == WIN_SCORE, else go to SERVE with the counter cleared.
  - No game_tick is issued in POINT.
- OVER:
  - game_over=1, no ticks, scores held.
  - Start edge: scores cleared, serve_dir=1, go to SERVE.
- Scores saturate at WIN_SCORE and never wrap.
- Pause:
  - A pause edge toggles paused, only in SERVE or PLAY.
  - While paused, game_tick, the SERVE counter, the tick divider and serve are frozen.
  - A miss while paused is still scored.
  - paused is cleared on entering POINT, OVER or ATTRACT.
- Start edge in SERVE, PLAY or POINT is ignored.
- A start edge and a pause edge in the same cycle are each handled per the state rules above; they do not interact.
- sof with vid_tready=0 is not a frame start; the sof must re-present with a completed handshake.
- Reset asserted mid-frame or mid-game returns to the reset values immediately; no serve or tick pulse is emitted on release.

Test Plan:
- Reset release, 3 frames of stimulus -> state=0, game_tick pulses 1 cycle after each sof (3 pulses), scores 0, serve never asserted.
- Start edge, SERVE_FRAMES=4 -> state=1; serve pulses exactly once 1 cycle after the 4th sof with serve_dir=1; state=2 in the same cycle; no game_tick before that.
- PLAY with TICK_DIV=3 over 9 frames -> exactly 3 game_tick pulses (after sof 3, 6, 9); sof presented with vid_tready=0 never counts.
- Single and simultaneous misses in PLAY:
  - miss_left -> score_right=1, serve_dir=0, state=3, then SERVE after the next sof.
  - miss_left and miss_right in the same cycle -> scores unchanged, state=3.
- WIN_SCORE=2, two miss_right events -> score_left=2, state=4, game_over=1; further misses ignored; start edge -> scores 0, state=1.
- Pause in PLAY over 5 frames -> no game_tick; divider resumes from its frozen value after unpause; a pause edge in ATTRACT leaves paused=0; reset asserted mid-SERVE -> all outputs return to reset values asynchronously.
